axi4l_uart_regs: RTL and testbench

AXI4-lite responder (slave) exposing the UART control/status/data register file to an AXI4-lite initiator.
Converts register writes into a byte stream toward the UART transmitter and register reads into pops from the UART receiver.
Sits between the system AXI4-lite interconnect and the UART TX/RX cores.
Target of the UART environment's AXI4-lite master agent.

---
 rtl/axi4l_uart_regs.sv | 223 ++++++++++++++++++++++
 tb/tb_axi4l_uart_regs.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4l_uart_regs.sv
// AXI4-lite register file for a UART: CTRL/STATUS/TXDATA/RXDATA/SCRATCH.
// Writes feed a one-byte TX holding register; RXDATA reads pop a one-byte RX holding register.
module axi4l_uart_regs #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic                        rx_enable,
    output logic                        tx_enable
);
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_TXDATA  = 3'd2;
    localparam logic [2:0] REG_RXDATA  = 3'd3;
    localparam logic [2:0] REG_SCRATCH = 3'd4;

    logic                      aw_done, aw_done_n, w_done, w_done_n;
    logic [2:0]                aw_idx, aw_idx_n;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_n;
    logic [STRB_W-1:0]         wstrb_q, wstrb_n;
    logic                      awready_n, wready_n, bvalid_n, arready_n, rvalid_n;
    logic [1:0]                bresp_n, rresp_n;
    logic [AXI_DATA_WIDTH-1:0] rdata_n, scratch, scratch_n;
    logic                      rx_en_n, tx_en_n;
    logic                      tx_full, tx_full_n, tx_valid_n, tx_ovr, tx_ovr_n;
    logic [7:0]                tx_data_n, rx_byte, rx_byte_n;
    logic                      rx_full, rx_full_n, rx_ovr, rx_ovr_n, rx_pop;
    logic                      unused_bits;

    assign unused_bits = ^{s_axi_awaddr[AXI_ADDR_WIDTH-1:5], s_axi_awaddr[1:0],
                           s_axi_araddr[AXI_ADDR_WIDTH-1:5], s_axi_araddr[1:0]};

    // Next-state logic for both channels and the TX/RX holding registers.
    always_comb begin
        aw_done_n  = aw_done;
        w_done_n   = w_done;
        aw_idx_n   = aw_idx;
        wdata_n    = wdata_q;
        wstrb_n    = wstrb_q;
        bvalid_n   = s_axi_bvalid;
        bresp_n    = s_axi_bresp;
        rvalid_n   = s_axi_rvalid;
        rresp_n    = s_axi_rresp;
        rdata_n    = s_axi_rdata;
        scratch_n  = scratch;
        rx_en_n    = rx_enable;
        tx_en_n    = tx_enable;
        tx_full_n  = tx_full;
        tx_data_n  = tx_data;
        tx_ovr_n   = tx_ovr;
        rx_full_n  = rx_full;
        rx_byte_n  = rx_byte;
        rx_ovr_n   = rx_ovr;
        rx_pop     = 1'b0;

        if (s_axi_awready && s_axi_awvalid) begin
            aw_done_n = 1'b1;
            aw_idx_n  = s_axi_awaddr[4:2];
        end
        if (s_axi_wready && s_axi_wvalid) begin
            w_done_n = 1'b1;
            wdata_n  = s_axi_wdata;
            wstrb_n  = s_axi_wstrb;
        end
        if (s_axi_bvalid && s_axi_bready) begin
            bvalid_n = 1'b0;
        end
        if (tx_valid && tx_ready) begin
            tx_full_n = 1'b0;
        end

        // Perform the write the cycle after address and data are both held.
        if (aw_done && w_done && !s_axi_bvalid) begin
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
            bvalid_n  = 1'b1;
            bresp_n   = RESP_OKAY;
            case (aw_idx)
                REG_CTRL: begin
                    if (wstrb_q[0]) begin
                        rx_en_n = wdata_q[0];
                        tx_en_n = wdata_q[1];
                    end
                end
                REG_STATUS: begin
                    if (wstrb_q[0] && wdata_q[2]) rx_ovr_n = 1'b0;
                    if (wstrb_q[0] && wdata_q[3]) tx_ovr_n = 1'b0;
                end
                REG_TXDATA: begin
                    // A handshake this cycle does not free the register for this write.
                    if (!wstrb_q[0]) begin
                        bresp_n = RESP_SLVERR;
                    end else if (tx_full) begin
                        tx_ovr_n = 1'b1;
                        bresp_n  = RESP_SLVERR;
                    end else begin
                        tx_full_n = 1'b1;
                        tx_data_n = wdata_q[7:0];
                    end
                end
                REG_SCRATCH: begin
                    for (int i = 0; i < int'(STRB_W); i++) begin
                        if (wstrb_q[i]) scratch_n[8*i +: 8] = wdata_q[8*i +: 8];
                    end
                end
                default: bresp_n = RESP_SLVERR;
            endcase
        end

        if (s_axi_arready && s_axi_arvalid) begin
            rvalid_n = 1'b1;
            rresp_n  = RESP_OKAY;
            rdata_n  = '0;
            case (s_axi_araddr[4:2])
                REG_CTRL:    rdata_n[1:0] = {tx_enable, rx_enable};
                REG_STATUS:  rdata_n[3:0] = {tx_ovr, rx_ovr, rx_full, !tx_full};
                REG_RXDATA: begin
                    rdata_n[7:0] = rx_full ? rx_byte : 8'h00;
                    rx_pop       = rx_full;
                end
                REG_SCRATCH: rdata_n = scratch;
                default:     rresp_n = RESP_SLVERR;
            endcase
        end else if (s_axi_rvalid && s_axi_rready) begin
            rvalid_n = 1'b0;
        end

        // Pop is applied before the incoming byte, so pop+arrival never overruns.
        if (rx_pop) rx_full_n = 1'b0;
        if (rx_valid && rx_enable) begin
            if (rx_full && !rx_pop) begin
                rx_ovr_n = 1'b1;
            end else begin
                rx_full_n = 1'b1;
                rx_byte_n = rx_data;
            end
        end

        awready_n  = !aw_done_n && !bvalid_n;
        wready_n   = !w_done_n && !bvalid_n;
        arready_n  = !rvalid_n;
        tx_valid_n = tx_full_n && tx_en_n;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            aw_idx        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rdata   <= '0;
            scratch       <= '0;
            rx_enable     <= 1'b0;
            tx_enable     <= 1'b0;
            tx_full       <= 1'b0;
            tx_valid      <= 1'b0;
            tx_data       <= '0;
            tx_ovr        <= 1'b0;
            rx_full       <= 1'b0;
            rx_byte       <= '0;
            rx_ovr        <= 1'b0;
        end else begin
            aw_done       <= aw_done_n;
            w_done        <= w_done_n;
            aw_idx        <= aw_idx_n;
            wdata_q       <= wdata_n;
            wstrb_q       <= wstrb_n;
            s_axi_awready <= awready_n;
            s_axi_wready  <= wready_n;
            s_axi_bvalid  <= bvalid_n;
            s_axi_bresp   <= bresp_n;
            s_axi_arready <= arready_n;
            s_axi_rvalid  <= rvalid_n;
            s_axi_rresp   <= rresp_n;
            s_axi_rdata   <= rdata_n;
            scratch       <= scratch_n;
            rx_enable     <= rx_en_n;
            tx_enable     <= tx_en_n;
            tx_full       <= tx_full_n;
            tx_valid      <= tx_valid_n;
            tx_data       <= tx_data_n;
            tx_ovr        <= tx_ovr_n;
            rx_full       <= rx_full_n;
            rx_byte       <= rx_byte_n;
            rx_ovr        <= rx_ovr_n;
        end
    end
endmodule

// File: tb/tb_axi4l_uart_regs.sv
// Directed bench for axi4l_uart_regs: register-map vector table plus TX/RX,
// backpressure and reset-abort sequences.
module tb_axi4l_uart_regs;
    localparam int TMO = 50;
    localparam logic [1:0] OK = 2'b00;
    localparam logic [1:0] SE = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready, rvalid, rready = 1'b0;
    logic [7:0]  tx_data, rx_data = '0;
    logic        tx_valid, tx_ready = 1'b0, rx_valid = 1'b0, rx_enable, tx_enable;

    int total = 0;
    int passed = 0;

    axi4l_uart_regs dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_enable(rx_enable), .tx_enable(tx_enable)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        total++;
        $display("FAIL %s: timeout waiting on DUT", name);
    endtask

    task automatic aw_send(input logic [31:0] a);
        int n = 0;
        awaddr = a; awvalid = 1'b1;
        while (!awready && n < TMO) begin @(negedge clk); n++; end
        if (!awready) timeout("awready");
        @(negedge clk); awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        while (!wready && n < TMO) begin @(negedge clk); n++; end
        if (!wready) timeout("wready");
        @(negedge clk); wvalid = 1'b0;
    endtask

    // mode 0: AW and W together, 1: AW first, 2: W first. hold_b stalls B for 5 cycles.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int mode, input bit hold_b, output logic [1:0] resp);
        int n = 0;
        if (mode == 0) begin
            fork
                aw_send(a);
                w_send(d, s);
            join
        end else if (mode == 1) begin
            aw_send(a); w_send(d, s);
        end else begin
            w_send(d, s); aw_send(a);
        end
        bready = !hold_b;
        while (!bvalid && n < TMO) begin @(negedge clk); n++; end
        if (!bvalid) timeout("bvalid");
        resp = bresp;
        if (hold_b) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("b_held", {30'd0, bvalid, awready}, 32'h2);
            end
            bready = 1'b1;
        end
        @(negedge clk); bready = 1'b0;
    endtask

    // inject drives an rx byte on the same edge as the AR handshake.
    task automatic axi_read(input logic [31:0] a, input bit inject, input logic [7:0] b,
                            output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < TMO) begin @(negedge clk); n++; end
        if (!arready) timeout("arready");
        if (inject) begin rx_valid = 1'b1; rx_data = b; end
        @(negedge clk); arvalid = 1'b0; rx_valid = 1'b0;
        n = 0;
        while (!rvalid && n < TMO) begin @(negedge clk); n++; end
        if (!rvalid) timeout("rvalid");
        d = rdata; resp = rresp; rready = 1'b1;
        @(negedge clk); rready = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        @(negedge clk); rx_valid = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a,
                          input logic [31:0] exp_d, input logic [1:0] exp_r);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, 1'b0, 8'h00, d, r);
        check(name, d, exp_d);
        check({name, "_resp"}, {30'd0, r}, {30'd0, exp_r});
    endtask

    task automatic wr_chk(input string name, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] exp_r);
        logic [1:0] r;
        axi_write(a, d, s, 0, 1'b0, r);
        check(name, {30'd0, r}, {30'd0, exp_r});
    endtask

    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          mode;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic [31:0] d;
        logic [1:0]  r;

        tbl[0]  = '{1'b1, 32'h04, 32'h0, 4'h0, 0, 32'h1, OK};
        tbl[1]  = '{1'b1, 32'h00, 32'h0, 4'h0, 0, 32'h0, OK};
        tbl[2]  = '{1'b1, 32'h10, 32'h0, 4'h0, 0, 32'h0, OK};
        tbl[3]  = '{1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1, 32'h0, OK};
        tbl[4]  = '{1'b0, 32'h10, 32'h00000011, 4'h1, 2, 32'h0, OK};
        tbl[5]  = '{1'b1, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBE11, OK};
        tbl[6]  = '{1'b0, 32'h10, 32'h12345678, 4'h6, 0, 32'h0, OK};
        tbl[7]  = '{1'b1, 32'h10, 32'h0, 4'h0, 0, 32'hDE345611, OK};
        tbl[8]  = '{1'b1, 32'h10000010, 32'h0, 4'h0, 0, 32'hDE345611, OK};
        tbl[9]  = '{1'b1, 32'h1C, 32'h0, 4'h0, 0, 32'h0, SE};
        tbl[10] = '{1'b0, 32'h14, 32'hFFFFFFFF, 4'hF, 0, 32'h0, SE};
        tbl[11] = '{1'b1, 32'h08, 32'h0, 4'h0, 0, 32'h0, SE};
        tbl[12] = '{1'b0, 32'h0C, 32'h000000AA, 4'h1, 0, 32'h0, SE};
        tbl[13] = '{1'b0, 32'h00, 32'h00000003, 4'hF, 1, 32'h0, OK};
        tbl[14] = '{1'b1, 32'h00, 32'h0, 4'h0, 0, 32'h3, OK};
        tbl[15] = '{1'b0, 32'h00, 32'h00000000, 4'hF, 2, 32'h0, OK};
        tbl[16] = '{1'b1, 32'h04, 32'h0, 4'h0, 0, 32'h1, OK};
        tbl[17] = '{1'b0, 32'h08, 32'h00000055, 4'h2, 0, 32'h0, SE};
        tbl[18] = '{1'b1, 32'h04, 32'h0, 4'h0, 0, 32'h1, OK};

        // Reset held for 3 cycles: every handshake output low.
        repeat (3) @(negedge clk);
        check("reset_outputs", {26'd0, awready, wready, arready, bvalid, rvalid, tx_valid}, 32'h0);
        check("reset_tx_data", {24'd0, tx_data}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            if (tbl[i].is_rd) begin
                axi_read(tbl[i].addr, 1'b0, 8'h00, d, r);
                check($sformatf("vec%0d_rdata", i), d, tbl[i].exp_data);
            end else begin
                axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].mode, 1'b0, r);
            end
            check($sformatf("vec%0d_resp", i), {30'd0, r}, {30'd0, tbl[i].exp_resp});
        end

        // TX: load, overrun while held, drain, W1C.
        wr_chk("ctrl_tx", 32'h00, 32'h2, 4'h1, OK);
        check("enables", {30'd0, tx_enable, rx_enable}, 32'h2);
        wr_chk("tx_load", 32'h08, 32'h41, 4'h1, OK);
        check("tx_out", {23'd0, tx_valid, tx_data}, 32'h141);
        rd_chk("status_txfull", 32'h04, 32'h0, OK);
        wr_chk("tx_overrun", 32'h08, 32'h42, 4'h1, SE);
        rd_chk("status_txovr", 32'h04, 32'h8, OK);
        check("tx_data_kept", {24'd0, tx_data}, 32'h41);
        tx_ready = 1'b1;
        @(negedge clk);
        check("tx_valid_drop", {31'd0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
        rd_chk("status_txempty", 32'h04, 32'h9, OK);
        wr_chk("status_w1c_tx", 32'h04, 32'h8, 4'h1, OK);
        rd_chk("status_cleared_tx", 32'h04, 32'h1, OK);

        // RX: fill, overrun, pop, W1C, empty read, pop coinciding with arrival.
        wr_chk("ctrl_rx", 32'h00, 32'h1, 4'h1, OK);
        rx_pulse(8'h5A);
        rx_pulse(8'h33);
        rd_chk("status_rx", 32'h04, 32'h7, OK);
        rd_chk("rxdata", 32'h0C, 32'h5A, OK);
        rd_chk("status_popped", 32'h04, 32'h5, OK);
        wr_chk("status_w1c_rx", 32'h04, 32'h4, 4'h1, OK);
        rd_chk("status_cleared_rx", 32'h04, 32'h1, OK);
        rd_chk("rxdata_empty", 32'h0C, 32'h0, OK);
        rx_pulse(8'h11);
        axi_read(32'h0C, 1'b1, 8'h22, d, r);
        check("pop_same_cycle", d, 32'h11);
        rd_chk("status_no_ovr", 32'h04, 32'h3, OK);
        rd_chk("rxdata_second", 32'h0C, 32'h22, OK);
        wr_chk("ctrl_off", 32'h00, 32'h0, 4'h1, OK);
        rx_pulse(8'h77);
        rd_chk("rx_disabled", 32'h04, 32'h1, OK);

        // B backpressure.
        axi_write(32'h10, 32'hCAFEF00D, 4'hF, 0, 1'b1, r);
        check("bp_resp", {30'd0, r}, {30'd0, OK});
        rd_chk("bp_scratch", 32'h10, 32'hCAFEF00D, OK);

        // Reset after AW only: transaction abandoned, W alone must not complete a write.
        aw_send(32'h10);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        w_send(32'h12345678, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_b_after_reset", {31'd0, bvalid}, 32'h0);
        end
        rd_chk("scratch_after_reset", 32'h10, 32'h0, OK);
        rd_chk("ctrl_after_reset", 32'h00, 32'h0, OK);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
